// File: rtl/audio_feature_extractor.sv
// Frame-based zero-crossing, energy and DC-removed amplitude extractor for the left I2S channel.
// Optional macro FEATURE_DC_REMOVE_EN: subtract the previous frame mean before the amplitude sum.
module audio_feature_extractor #(
  parameter int LOG2_FRAME = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] sample_in,
  input  logic        sample_valid,
  output logic [5:0]  zcr_count_left,
  output logic        zcr_valid_left,
  output logic [30:0] ste_left,
  output logic        ste_left_valid,
  output logic [15:0] subMean_left_out,
  output logic        subMean_left_valid
);

  typedef enum logic [1:0] {IDLE, ACC, EMIT} state_t;

  state_t state, state_next;

  logic [LOG2_FRAME-1:0]  cnt;
  logic                   accept;
  logic                   last;
  logic                   prev_sign;
  logic                   zc_inc;
  logic [5:0]             zcr_acc, zcr_sum;
  logic [15:0]            ax;
  logic [30:0]            sq;
  logic [30+LOG2_FRAME:0] ste_acc, ste_sum;
  logic [15:0]            dc;
  logic [16:0]            d;
  logic [15:0]            d_abs;
  logic [15+LOG2_FRAME:0] amp_acc, amp_sum;

  assign accept = (state == ACC) && en && sample_valid;
  assign last   = &cnt;

  // The first sample of a frame only seeds prev_sign.
  assign zc_inc  = (cnt != '0) && (sample_in[15] != prev_sign);
  assign zcr_sum = zcr_acc + {5'b0, zc_inc};

  // Squaring the magnitude keeps the product unsigned; -32768 maps to 32768.
  assign ax      = sample_in[15] ? (~sample_in + 16'd1) : sample_in;
  assign sq      = 31'(ax) * 31'(ax);
  assign ste_sum = ste_acc + {{LOG2_FRAME{1'b0}}, sq};

  assign d       = {sample_in[15], sample_in} - {dc[15], dc};
  assign d_abs   = d[16] ? (~d[15:0] + 16'd1) : d[15:0];
  assign amp_sum = amp_acc + {{LOG2_FRAME{1'b0}}, d_abs};

`ifdef FEATURE_DC_REMOVE_EN
  logic signed [15+LOG2_FRAME:0] x_acc, x_sum;

  assign x_sum = x_acc + {{LOG2_FRAME{sample_in[15]}}, sample_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      dc    <= '0;
      x_acc <= '0;
    end else if (accept) begin
      if (last) begin
        dc    <= 16'(x_sum >>> LOG2_FRAME);
        x_acc <= '0;
      end else begin
        x_acc <= x_sum;
      end
    end else if (!en || state != ACC) begin
      x_acc <= '0;
    end
  end
`else
  assign dc = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = ACC;
      ACC: begin
        if (!en)                state_next = IDLE;
        else if (accept && last) state_next = EMIT;
      end
      EMIT:    state_next = en ? ACC : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs load on the edge that accepts the last sample; accumulators restart there too.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt              <= '0;
      prev_sign        <= 1'b0;
      zcr_acc          <= '0;
      ste_acc          <= '0;
      amp_acc          <= '0;
      zcr_count_left   <= '0;
      ste_left         <= '0;
      subMean_left_out <= '0;
    end else if (accept) begin
      prev_sign <= sample_in[15];
      if (last) begin
        cnt              <= '0;
        zcr_acc          <= '0;
        ste_acc          <= '0;
        amp_acc          <= '0;
        zcr_count_left   <= zcr_sum;
        ste_left         <= 31'(ste_sum >> LOG2_FRAME);
        subMean_left_out <= 16'(amp_sum >> LOG2_FRAME);
      end else begin
        cnt     <= cnt + 1'b1;
        zcr_acc <= zcr_sum;
        ste_acc <= ste_sum;
        amp_acc <= amp_sum;
      end
    end else if (!en || state != ACC) begin
      cnt     <= '0;
      zcr_acc <= '0;
      ste_acc <= '0;
      amp_acc <= '0;
    end
  end

  assign zcr_valid_left     = (state == EMIT);
  assign ste_left_valid     = (state == EMIT);
  assign subMean_left_valid = (state == EMIT);

endmodule

// File: tb/tb_audio_feature_extractor.sv
// Self-checking bench for audio_feature_extractor: a frame-level reference model checked every cycle,
// plus directed frames with hand-computed feature values and a randomized phase.
module tb_audio_feature_extractor;

  localparam int L = 5;
  localparam int N = 1 << L;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [5:0]  zcr_count_left;
  logic        zcr_valid_left;
  logic [30:0] ste_left;
  logic        ste_left_valid;
  logic [15:0] subMean_left_out;
  logic        subMean_left_valid;

  int num_checks = 0;
  int num_fail = 0;

  // Reference model state: 0 idle, 1 accumulating, 2 emitting.
  int     m_state = 0;
  int     frame[$];
  longint m_dc = 0;
  logic   exp_valid = 1'b0;
  longint exp_zcr = 0, exp_ste = 0, exp_sub = 0;

  audio_feature_extractor #(.LOG2_FRAME(L)) dut (
    .clk                (clk),
    .rst                (rst),
    .en                 (en),
    .sample_in          (sample_in),
    .sample_valid       (sample_valid),
    .zcr_count_left     (zcr_count_left),
    .zcr_valid_left     (zcr_valid_left),
    .ste_left           (ste_left),
    .ste_left_valid     (ste_left_valid),
    .subMean_left_out   (subMean_left_out),
    .subMean_left_valid (subMean_left_valid)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input longint act, input longint exp);
    num_checks++;
    if (act !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void compute_frame();
    longint zc = 0, e = 0, a = 0, s = 0, dd;
    for (int i = 0; i < N; i++) begin
      if (i > 0 && ((frame[i] < 0) != (frame[i-1] < 0))) zc++;
      e += longint'(frame[i]) * longint'(frame[i]);
      dd = longint'(frame[i]) - m_dc;
      a += (dd < 0) ? -dd : dd;
      s += frame[i];
    end
    exp_zcr = zc;
    exp_ste = e / N;
    exp_sub = a / N;
`ifdef FEATURE_DC_REMOVE_EN
    m_dc = s >>> L;
`endif
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_state = 0;
      frame.delete();
      m_dc = 0;
      exp_valid = 1'b0;
      exp_zcr = 0;
      exp_ste = 0;
      exp_sub = 0;
    end else begin
      exp_valid = 1'b0;
      case (m_state)
        0: if (en) m_state = 1;
        1: begin
          if (!en) begin
            frame.delete();
            m_state = 0;
          end else if (sample_valid) begin
            frame.push_back(int'($signed(sample_in)));
            if (frame.size() == N) begin
              compute_frame();
              frame.delete();
              exp_valid = 1'b1;
              m_state = 2;
            end
          end
        end
        default: m_state = en ? 1 : 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check_output("zcr_valid", longint'(zcr_valid_left), longint'(exp_valid));
    check_output("ste_valid", longint'(ste_left_valid), longint'(exp_valid));
    check_output("sub_valid", longint'(subMean_left_valid), longint'(exp_valid));
    check_output("zcr", longint'(zcr_count_left), exp_zcr);
    check_output("ste", longint'(ste_left), exp_ste);
    check_output("sub", longint'(subMean_left_out), exp_sub);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [15:0] s, input int gap);
    sample_in = s;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    repeat (gap) step();
  endtask

  // The last sample is sent with no trailing gap so the caller lands in the emit cycle.
  task automatic send_frame(input int v, input bit alt, input int max_gap, input int count);
    int g;
    for (int i = 0; i < count; i++) begin
      g = (i == count - 1 || max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
      apply_stimulus((alt && i[0]) ? 16'(-v) : 16'(v), g);
    end
  endtask

  task automatic check_frame(input string tag, input longint zc, input longint ste, input longint sub);
    int waited = 0;
    while (!zcr_valid_left && waited < 64) begin
      step();
      waited++;
    end
    check_output({tag, "_pulse"}, longint'(zcr_valid_left), 1);
    check_output({tag, "_zcr"}, longint'(zcr_count_left), zc);
    check_output({tag, "_ste"}, longint'(ste_left), ste);
    if (sub >= 0) check_output({tag, "_sub"}, longint'(subMean_left_out), sub);
    step();
    check_output({tag, "_pulse_end"}, longint'(zcr_valid_left), 0);
  endtask

  initial begin
    repeat (2) step();
    rst = 1'b0;
    check_output("reset_ste", longint'(ste_left), 0);
    check_output("reset_valid", longint'(zcr_valid_left), 0);

    en = 1'b1;
    step();
    send_frame(1000, 1'b0, 0, N);
    check_frame("t1", 0, 1000000, 1000);
    send_frame(1000, 1'b0, 0, N);
`ifdef FEATURE_DC_REMOVE_EN
    check_frame("t1_repeat", 0, 1000000, 0);
`else
    check_frame("t1_repeat", 0, 1000000, 1000);
`endif

    do_reset();
    step();
    send_frame(100, 1'b1, 0, N);
    check_frame("t2", 31, 10000, 100);

    do_reset();
    step();
    send_frame(-32768, 1'b0, 0, N);
    check_frame("t3_min", 0, 1073741824, 32768);
    send_frame(32767, 1'b0, 0, N);
`ifdef FEATURE_DC_REMOVE_EN
    check_frame("t3_max", 0, 1073676289, 65535);
`else
    check_frame("t3_max", 0, 1073676289, 32767);
`endif

    do_reset();
    step();
    send_frame(1000, 1'b0, 5, N);
    check_frame("t4", 0, 1000000, 1000);

    send_frame(-2000, 1'b0, 1, 10);
    en = 1'b0;
    repeat (2) step();
    check_output("t5_abort_valid", longint'(zcr_valid_left), 0);
    en = 1'b1;
    step();
    send_frame(1000, 1'b0, 0, N);
    check_frame("t5", 0, 1000000, -1);

    send_frame(500, 1'b0, 0, 20);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_output("t6_rst_ste", longint'(ste_left), 0);
    check_output("t6_rst_zcr", longint'(zcr_count_left), 0);
    check_output("t6_rst_sub", longint'(subMean_left_out), 0);
    step();
    send_frame(500, 1'b0, 0, N);
    check_frame("t6", 0, 250000, 500);

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N; i++) begin
        logic [15:0] v;
        case ($urandom_range(0, 3))
          0:       v = 16'($urandom);
          1:       v = 16'h8000;
          2:       v = 16'h7fff;
          default: v = 16'($signed(10'($urandom)));
        endcase
        if ($urandom_range(0, 99) < 2) begin
          en = 1'b0;
          step();
          en = 1'b1;
          step();
        end
        apply_stimulus(v, int'($urandom_range(0, 3)));
      end
    end
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
